// File: rtl/lap_memory_pkg.sv
// Shared types and constants for the lap/split recorder.
package lap_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    HOLD   = 2'd1,
    RECALL = 2'd2
  } state_t;

endpackage

// File: rtl/lap_memory_if.sv
// Time, button and display bundle between the stopwatch controller and lap_memory.
interface lap_memory_if import lap_pkg::*; #(
  parameter int NDIGITS = 4,
  parameter int DEPTH   = 8
);
  localparam int DATA_W = DIGIT_W * NDIGITS;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] time_in;
  logic              start;
  logic              stop;
  logic              lapButton;
  logic              recallButton;
  logic              clearButton;
  logic [DATA_W-1:0] display;
  logic [CNT_W-1:0]  lap_count;
  logic [IDX_W-1:0]  recall_idx;
  logic              showing_lap;
  logic              full;

  modport master (
    output time_in, start, stop, lapButton, recallButton, clearButton,
    input  display, lap_count, recall_idx, showing_lap, full
  );

  modport slave (
    input  time_in, start, stop, lapButton, recallButton, clearButton,
    output display, lap_count, recall_idx, showing_lap, full
  );
endinterface

// File: rtl/lap_memory_rise_detect.sv
// Single-bit rising-edge detector; history resets high so a level held through reset is not an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist_q <= 1'b1;
    else        hist_q <= level;
  end

  assign rise = level & ~hist_q;

endmodule

// File: rtl/lap_memory.sv
// Lap/split recorder: circular lap store, hold-on-lap display and recall stepping.
module lap_memory import lap_pkg::*; #(
  parameter int NDIGITS = 4,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  lap_memory_if.slave bus
);

  localparam int DATA_W = DIGIT_W * NDIGITS;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic start_r, stop_r, lap_r, recall_r, clear_r;

  rise_detect u_start  (.clk(clk), .reset(reset), .level(bus.start),        .rise(start_r));
  rise_detect u_stop   (.clk(clk), .reset(reset), .level(bus.stop),         .rise(stop_r));
  rise_detect u_lap    (.clk(clk), .reset(reset), .level(bus.lapButton),    .rise(lap_r));
  rise_detect u_recall (.clk(clk), .reset(reset), .level(bus.recallButton), .rise(recall_r));
  rise_detect u_clear  (.clk(clk), .reset(reset), .level(bus.clearButton),  .rise(clear_r));

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              showing_q, full_q;
  logic              capture;

  // Logical lap index -> physical slot; wraps naturally in IDX_W bits.
  function automatic logic [IDX_W-1:0] phys(input logic [IDX_W-1:0] ptr,
                                            input logic [CNT_W-1:0] cnt,
                                            input logic [IDX_W-1:0] i);
    return ptr - cnt[IDX_W-1:0] + i;
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    if (clear_r) begin
      state_d  = LIVE;
      count_d  = '0;
      wr_ptr_d = '0;
      idx_d    = '0;
    end else if (lap_r) begin
      capture  = 1'b1;
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (count_q != FULL_CNT) count_d = count_q + CNT_W'(1);
      state_d  = HOLD;
    end else if ((start_r || stop_r) && state_q != LIVE) begin
      state_d = LIVE;
    end else if (recall_r && count_q != '0) begin
      if (state_q == RECALL) begin
        idx_d = (CNT_W'(idx_q) == count_q - CNT_W'(1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        state_d = RECALL;
        idx_d   = '0;
      end
    end

    // Recall never coincides with a capture, so the current pointer/count address the store.
    case (state_d)
      HOLD:    display_d = capture ? bus.time_in : hold_q;
      RECALL:  display_d = mem[phys(wr_ptr_q, count_q, idx_d)];
      default: display_d = bus.time_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LIVE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      idx_q     <= '0;
      display_q <= '0;
      showing_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      showing_q <= (state_d != LIVE);
      full_q    <= (count_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_q] <= bus.time_in;
      hold_q        <= bus.time_in;
    end
  end

  assign bus.display     = display_q;
  assign bus.lap_count   = count_q;
  assign bus.recall_idx  = idx_q;
  assign bus.showing_lap = showing_q;
  assign bus.full        = full_q;

endmodule
